manchester_bit_seq: RTL and testbench
=====================================

Name: manchester_bit_seq

Overview:
- Sequences the IQ convolution integrator of the Manchester receiver, one bit window at a time.
- Clears the integrator at each window start and gates its enable with the sample strobe. Captures the final I/Q sums and slices the bit.
- Applies ±1-sample window-length adjustment from the Q energy for timing recovery.
- Delivers decoded bits to the frame logic over a valid/ready handshake and reports lock/erasure/overrun status.

Parameters:
- SPB, 16: nominal samples per bit window; adjusted window is SPB-1..SPB+1, max 17, which fits the 5-bit sums.
- MARGIN, 3: I decision margin around SPB/2; |isum - SPB/2| < MARGIN is an erasure.
- QTOL, 2: Q deadband; no window adjust while |qsum - SPB/2| <= QTOL.
- LOCK_CNT, 4: consecutive non-erased bits required to assert locked.

Ports:
- clk  in  1  sample clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  level; high runs the sequencer, low returns it to IDLE at the next window boundary
- samp_en  in  1  sample strobe, one cycle per raw sample
- isum  in  5  integrator I sum (includes the current sample)
- qsum  in  5  integrator Q sum (includes the current sample)
- conv_enable  out  1  integrator enable
- conv_reset  out  1  integrator synchronous clear
- bit_out  out  1  decoded bit
- bit_erase  out  1  erasure tag, qualified by bit_valid
- bit_valid  out  1  output holds an undelivered bit
- bit_ready  in  1  consumer accepts the bit when valid and ready are both high
- locked  out  1  lock indicator
- overrun  out  1  sticky; set when a bit is dropped because the output is full
- win_len  out  5  current window length, for debug

Behaviour:
- Reset values: state = IDLE, conv_enable = 0, conv_reset = 1, bit_out = 0, bit_erase = 0, bit_valid = 0, locked = 0, overrun = 0, win_len = SPB, sample counter = 0, good-bit counter = 0.
- IDLE:
  - conv_reset = 1, conv_enable = 0.
  - start = 1 moves to CLEAR on the next cycle.
- CLEAR: exactly one cycle.
  - conv_reset = 1, sample counter = 0.
  - Next state is INTEG.
- INTEG:
  - conv_enable = samp_en (combinational), conv_reset = 0.
  - Each samp_en increments the sample counter.
  - On the samp_en cycle where counter + 1 == win_len, register isum/qsum into capture registers and go to DECIDE.
  - start deasserted mid-window has no effect until the window completes.
- DECIDE: one cycle, conv_enable = 0. All of the following take effect on the same edge:
  - Bit slicing on the captured I sum (ci), with H = win_len/2 (integer floor):
    - ci <= H - MARGIN: bit = 0, not erased.
    - ci >= H + MARGIN: bit = 1, not erased.
    - Otherwise: bit = 0 and erased.
  - Window adjust, with the next window length clamped to SPB-1..SPB+1:
    - captured Q sum (cq) < H - QTOL: next win_len = SPB + 1.
    - cq > H + QTOL: next win_len = SPB - 1.
    - Otherwise: next win_len = SPB.
    - The adjustment is non-cumulative: it always restarts from SPB.
  - Lock tracking:
    - A non-erased bit increments the good-bit counter, saturating at LOCK_CNT; locked = 1 when the count reaches LOCK_CNT.
    - An erased bit clears both the counter and locked.
  - Output register:
    - If bit_valid = 0, or bit_valid = 1 with bit_ready = 1 on this cycle, load bit_out/bit_erase and set bit_valid = 1.
    - Otherwise drop the new bit, keep the old one, and set overrun = 1.
  - Next state:
    - start = 1: go to CLEAR. Total window overhead is 2 cycles (DECIDE + CLEAR), so samp_en spacing must be >= 3 cycles.
    - start = 0: go to IDLE.
- Handshake:
  - bit_valid clears on a cycle with valid and ready both high, unless DECIDE reloads it on that same cycle (new bit wins).
  - bit_out/bit_erase stay stable while valid is high and ready is low.
- samp_en during CLEAR or DECIDE is ignored and is not counted.
- overrun clears only on reset.
- reset asserted mid-operation: all state returns to reset values on the next edge, including outputs; any in-flight bit is discarded.
- Latency: bit_valid rises 2 clk after the final-sample samp_en edge.

Test Plan:
- Window length and sums:
  - Stimulus: reset, start = 1, samp_en every 4 cycles, samp = i_wf for 16 samples, so isum = 0 and qsum = 8.
  - Required: conv_reset pulses exactly once before the window; bit_out = 0, erase = 0, bit_valid 2 clk after the 16th strobe; win_len stays 16.
- Bit-1 path and lock:
  - Stimulus: isum = 16 for 4 consecutive windows, bit_ready = 1.
  - Required: four bits = 1; locked rises on the DECIDE of the 4th window.
- Erasure:
  - Stimulus: isum = 7 (H = 8, MARGIN = 3).
  - Required: bit_erase = 1, locked drops to 0, good-bit counter resets.
- Timing adjust and clamp:
  - Stimulus: qsum = 3.
  - Required: next win_len = 17, and exactly 17 strobes are counted. Then qsum = 14 gives win_len = 15. Two successive qsum = 3 windows stay at 17.
- Backpressure:
  - Stimulus: bit_ready = 0 across two DECIDEs.
  - Required: the first bit is held stable and the second is dropped; overrun = 1 and stays sticky until reset. A ready pulse coincident with a DECIDE delivers the old bit and loads the new one with no overrun.
- Reset and stop:
  - Stimulus: reset at sample 9 of a window.
  - Required: all outputs return to reset values next edge; no bit is emitted. Dropping start mid-window: the window completes, the bit is emitted, then IDLE with conv_reset = 1.

Source files
------------

// File: rtl/manchester_bit_seq.sv
// manchester_bit_seq: per-bit-window sequencer for the Manchester IQ integrator.
// Rev 1.0 - slices I, nudges window length from Q, hands bits out over valid/ready.
`default_nettype none

module manchester_bit_seq #(
  parameter int SPB      = 16,
  parameter int MARGIN   = 3,
  parameter int QTOL     = 2,
  parameter int LOCK_CNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       samp_en,
  input  logic [4:0] isum,
  input  logic [4:0] qsum,
  output logic       conv_enable,
  output logic       conv_reset,
  output logic       bit_out,
  output logic       bit_erase,
  output logic       bit_valid,
  input  logic       bit_ready,
  output logic       locked,
  output logic       overrun,
  output logic [4:0] win_len
);

  localparam int GW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    INTEG  = 2'd2,
    DECIDE = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [4:0]      r_cnt;
  logic [4:0]      r_ci;
  logic [4:0]      r_cq;
  logic [4:0]      r_win_len;
  logic [GW-1:0]   r_good;
  logic            r_bit;
  logic            r_erase;
  logic            r_valid;
  logic            r_locked;
  logic            r_overrun;

  logic            w_last;
  logic [6:0]      w_h;
  logic [6:0]      w_ci;
  logic [6:0]      w_cq;
  logic            w_is_zero;
  logic            w_is_one;
  logic            w_erase;
  logic            w_q_early;
  logic            w_q_late;
  logic            w_load;

  assign w_last = samp_en && ((r_cnt + 5'd1) == r_win_len);

  // Thresholds compared in 7 bits with margins moved to the sum side, so no underflow.
  assign w_h       = {3'd0, r_win_len[4:1]};
  assign w_ci      = {2'd0, r_ci};
  assign w_cq      = {2'd0, r_cq};
  assign w_is_zero = (w_ci + 7'(MARGIN)) <= w_h;
  assign w_is_one  = w_ci >= (w_h + 7'(MARGIN));
  assign w_erase   = !(w_is_zero || w_is_one);
  assign w_q_early = (w_cq + 7'(QTOL)) < w_h;
  assign w_q_late  = w_cq > (w_h + 7'(QTOL));
  assign w_load    = !r_valid || bit_ready;

  always_comb begin
    state_nxt   = state;
    conv_enable = 1'b0;
    conv_reset  = 1'b0;
    case (state)
      IDLE: begin
        conv_reset = 1'b1;
        if (start) state_nxt = CLEAR;
      end
      CLEAR: begin
        conv_reset = 1'b1;
        state_nxt  = INTEG;
      end
      INTEG: begin
        conv_enable = samp_en;
        if (w_last) state_nxt = DECIDE;
      end
      DECIDE: begin
        state_nxt = start ? CLEAR : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      r_cnt     <= 5'd0;
      r_ci      <= 5'd0;
      r_cq      <= 5'd0;
      r_win_len <= 5'(SPB);
      r_good    <= '0;
      r_bit     <= 1'b0;
      r_erase   <= 1'b0;
      r_valid   <= 1'b0;
      r_locked  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == CLEAR) begin
        r_cnt <= 5'd0;
      end else if (state == INTEG && samp_en) begin
        r_cnt <= r_cnt + 5'd1;
        if (w_last) begin
          r_ci <= isum;
          r_cq <= qsum;
        end
      end

      if (state == DECIDE) begin
        // Non-cumulative adjust: always relative to the nominal length.
        if (w_q_early)     r_win_len <= 5'(SPB + 1);
        else if (w_q_late) r_win_len <= 5'(SPB - 1);
        else               r_win_len <= 5'(SPB);

        if (w_erase) begin
          r_good   <= '0;
          r_locked <= 1'b0;
        end else begin
          if (r_good != GW'(LOCK_CNT)) r_good <= r_good + 1'b1;
          if (r_good >= GW'(LOCK_CNT - 1)) r_locked <= 1'b1;
        end

        if (w_load) begin
          r_bit   <= w_is_one;
          r_erase <= w_erase;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && bit_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bit_out   = r_bit;
  assign bit_erase = r_erase;
  assign bit_valid = r_valid;
  assign locked    = r_locked;
  assign overrun   = r_overrun;
  assign win_len   = r_win_len;

endmodule

`default_nettype wire

// File: tb/tb_manchester_bit_seq.sv
// tb_manchester_bit_seq: directed windows with hand-computed bit, erase, lock and length.
// Rev 1.0
`default_nettype none

module tb_manchester_bit_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic       samp_en;
  logic [4:0] isum;
  logic [4:0] qsum;
  logic       conv_enable;
  logic       conv_reset;
  logic       bit_out;
  logic       bit_erase;
  logic       bit_valid;
  logic       bit_ready;
  logic       locked;
  logic       overrun;
  logic [4:0] win_len;

  int n_checks = 0;
  int n_fail   = 0;

  manchester_bit_seq #(.SPB(16), .MARGIN(3), .QTOL(2), .LOCK_CNT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .samp_en     (samp_en),
    .isum        (isum),
    .qsum        (qsum),
    .conv_enable (conv_enable),
    .conv_reset  (conv_reset),
    .bit_out     (bit_out),
    .bit_erase   (bit_erase),
    .bit_valid   (bit_valid),
    .bit_ready   (bit_ready),
    .locked      (locked),
    .overrun     (overrun),
    .win_len     (win_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    samp_en = 1'b1;
    #1;
    check({tag, " conv_reset"},  32'(conv_reset),  32'd1);
    check({tag, " conv_enable"}, 32'(conv_enable), 32'd0);
    check({tag, " bit_valid"},   32'(bit_valid),   32'd0);
    check({tag, " bit_out"},     32'(bit_out),     32'd0);
    check({tag, " bit_erase"},   32'(bit_erase),   32'd0);
    check({tag, " locked"},      32'(locked),      32'd0);
    check({tag, " overrun"},     32'(overrun),     32'd0);
    check({tag, " win_len"},     32'(win_len),     32'd16);
    samp_en = 1'b0;
  endtask

  // Starts with the DUT in INTEG; ends two edges after the final strobe.
  task automatic run_window(input string tag, input int n, input logic [4:0] iv,
                            input logic [4:0] qv, input logic rdy, input logic rdy_dec,
                            input int stop_at, input logic exp_bit, input logic exp_erase,
                            input logic exp_valid, input logic exp_lock,
                            input logic exp_ovr, input logic [4:0] exp_len);
    int en_cnt = 0;
    int cr_cnt = 0;
    bit_ready = rdy;
    for (int k = 0; k < n; k++) begin
      samp_en = 1'b1;
      isum    = iv;
      qsum    = qv;
      #1;
      en_cnt += int'(conv_enable);
      cr_cnt += int'(conv_reset);
      tick();
      samp_en = 1'b0;
      if (k + 1 == stop_at) start = 1'b0;
      if (k < n - 1) begin
        for (int j = 0; j < 3; j++) begin
          cr_cnt += int'(conv_reset);
          tick();
        end
      end
    end
    check({tag, " strobes"},   32'(en_cnt), 32'(n));
    check({tag, " no_clear"},  32'(cr_cnt), 32'd0);
    if (rdy && rdy_dec) check({tag, " early_valid"}, 32'(bit_valid), 32'd0);
    bit_ready = rdy_dec;
    tick();
    bit_ready = rdy;
    check({tag, " bit"},       32'(bit_out),    32'(exp_bit));
    check({tag, " erase"},     32'(bit_erase),  32'(exp_erase));
    check({tag, " valid"},     32'(bit_valid),  32'(exp_valid));
    check({tag, " locked"},    32'(locked),     32'(exp_lock));
    check({tag, " overrun"},   32'(overrun),    32'(exp_ovr));
    check({tag, " win_len"},   32'(win_len),    32'(exp_len));
    check({tag, " clr1"},      32'(conv_reset), 32'd1);
    tick();
    check({tag, " clr2"},      32'(conv_reset), (stop_at != 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; samp_en = 1'b0;
    isum = 5'd0; qsum = 5'd0; bit_ready = 1'b1;
    tick();
    tick();
    check_reset_vals("por");

    reset = 1'b0;
    start = 1'b1;
    tick();
    check("clear_pulse", 32'(conv_reset), 32'd1);
    tick();
    check("integ_entry", 32'(conv_reset), 32'd0);

    //          tag    n   isum   qsum  rdy  rdyD stop bit er val lk ov len
    run_window("w01", 16, 5'd0,  5'd8,  1'b1, 1'b1, 0, 0, 0, 1, 0, 0, 5'd16);
    run_window("w02", 16, 5'd7,  5'd8,  1'b1, 1'b1, 0, 0, 1, 1, 0, 0, 5'd16);
    run_window("w03", 16, 5'd16, 5'd8,  1'b1, 1'b1, 0, 1, 0, 1, 0, 0, 5'd16);
    run_window("w04", 16, 5'd16, 5'd8,  1'b1, 1'b1, 0, 1, 0, 1, 0, 0, 5'd16);
    run_window("w05", 16, 5'd16, 5'd8,  1'b1, 1'b1, 0, 1, 0, 1, 0, 0, 5'd16);
    run_window("w06", 16, 5'd16, 5'd8,  1'b1, 1'b1, 0, 1, 0, 1, 1, 0, 5'd16);
    run_window("w07", 16, 5'd7,  5'd8,  1'b1, 1'b1, 0, 0, 1, 1, 0, 0, 5'd16);
    run_window("w08", 16, 5'd16, 5'd3,  1'b1, 1'b1, 0, 1, 0, 1, 0, 0, 5'd17);
    run_window("w09", 17, 5'd12, 5'd3,  1'b1, 1'b1, 0, 1, 0, 1, 0, 0, 5'd17);
    run_window("w10", 17, 5'd5,  5'd14, 1'b1, 1'b1, 0, 0, 0, 1, 0, 0, 5'd15);
    run_window("w11", 15, 5'd4,  5'd8,  1'b1, 1'b1, 0, 0, 0, 1, 1, 0, 5'd16);
    run_window("w12", 16, 5'd11, 5'd10, 1'b1, 1'b1, 0, 1, 0, 1, 1, 0, 5'd16);
    run_window("w13", 16, 5'd10, 5'd6,  1'b1, 1'b1, 0, 0, 1, 1, 0, 0, 5'd16);
    // Backpressure: hold, ready coincident with DECIDE, then a dropped bit.
    run_window("w14", 16, 5'd16, 5'd8,  1'b0, 1'b0, 0, 1, 0, 1, 0, 0, 5'd16);
    run_window("w15", 16, 5'd0,  5'd8,  1'b0, 1'b1, 0, 0, 0, 1, 0, 0, 5'd16);
    run_window("w16", 16, 5'd16, 5'd8,  1'b0, 1'b0, 0, 0, 0, 1, 0, 1, 5'd16);
    bit_ready = 1'b1;
    tick();
    check("drain valid",   32'(bit_valid), 32'd0);
    check("drain overrun", 32'(overrun),   32'd1);
    run_window("w17", 16, 5'd16, 5'd8,  1'b1, 1'b1, 0, 1, 0, 1, 1, 1, 5'd16);

    // Reset after the 9th sample of a window.
    for (int k = 0; k < 9; k++) begin
      samp_en = 1'b1;
      tick();
      samp_en = 1'b0;
      tick(); tick(); tick();
    end
    reset = 1'b1;
    start = 1'b0;
    tick();
    check_reset_vals("midrst");
    reset = 1'b0;
    tick(); tick(); tick();
    check("post_rst valid", 32'(bit_valid),  32'd0);
    check("post_rst clr",   32'(conv_reset), 32'd1);

    // Start drops mid-window: window completes, bit emitted, then IDLE.
    start = 1'b1;
    tick();
    tick();
    run_window("stop", 16, 5'd16, 5'd8, 1'b1, 1'b1, 5, 1, 0, 1, 0, 0, 5'd16);
    check("stop consumed", 32'(bit_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
